// File: rtl/music_pkg.sv
// ============================================================================
// Module   : music_pkg
// Brief    : Shared types and duration constants for note duration quantizing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package music_pkg;

  // Default width of a tone index (tone 0 is a rest).
  localparam int TONE_W_DEFAULT = 6;

  // Duration codes carried on ev_dur.
  typedef enum logic [2:0] {
    DUR_NONE    = 3'd0,
    DUR_16TH    = 3'd1,
    DUR_8TH     = 3'd2,
    DUR_QUARTER = 3'd3,
    DUR_HALF    = 3'd4,
    DUR_WHOLE   = 3'd5
  } dur_e;

  // Nominal length in samples of duration code k (1..5) at the given tempo.
  function automatic int unsigned dur_samples(input int unsigned sample_rate,
                                              input int unsigned bpm,
                                              input int unsigned k);
    int unsigned q;
    q = (sample_rate * 60) / bpm;
    case (k)
      1:       return q / 4;
      2:       return q / 2;
      3:       return q;
      4:       return 2 * q;
      default: return 4 * q;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/dur_classify.sv
// ============================================================================
// Module   : dur_classify
// Brief    : Combinational segment length -> duration code / dotted flag.
//            Optional macro NOTE_DURATION_DOTTED_EN builds the dotted test.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dur_classify
  import music_pkg::*;
#(
  parameter int SAMPLE_RATE = 17000,
  parameter int BPM         = 60,
  parameter int CNT_W       = 17
) (
  input  logic [CNT_W-1:0] len_i,
  output logic [2:0]       dur_o,
  output logic             dotted_o
);

  localparam int unsigned D1 = dur_samples(SAMPLE_RATE, BPM, 1);
  localparam int unsigned D2 = dur_samples(SAMPLE_RATE, BPM, 2);
  localparam int unsigned D3 = dur_samples(SAMPLE_RATE, BPM, 3);
  localparam int unsigned D4 = dur_samples(SAMPLE_RATE, BPM, 4);
  localparam int unsigned D5 = dur_samples(SAMPLE_RATE, BPM, 5);

  // A segment qualifies for code k once it reaches three quarters of Dk.
  localparam logic [CNT_W-1:0] TH1 = CNT_W'((3 * D1) / 4);
  localparam logic [CNT_W-1:0] TH2 = CNT_W'((3 * D2) / 4);
  localparam logic [CNT_W-1:0] TH3 = CNT_W'((3 * D3) / 4);
  localparam logic [CNT_W-1:0] TH4 = CNT_W'((3 * D4) / 4);
  localparam logic [CNT_W-1:0] TH5 = CNT_W'((3 * D5) / 4);

  // Pick the longest duration whose threshold the length reaches.
  always_comb begin
    dur_o = DUR_NONE;
    if (len_i >= TH5)      dur_o = DUR_WHOLE;
    else if (len_i >= TH4) dur_o = DUR_HALF;
    else if (len_i >= TH3) dur_o = DUR_QUARTER;
    else if (len_i >= TH2) dur_o = DUR_8TH;
    else if (len_i >= TH1) dur_o = DUR_16TH;
  end

`ifdef NOTE_DURATION_DOTTED_EN
  localparam logic [CNT_W-1:0] DT1 = CNT_W'((5 * D1) / 4);
  localparam logic [CNT_W-1:0] DT2 = CNT_W'((5 * D2) / 4);
  localparam logic [CNT_W-1:0] DT3 = CNT_W'((5 * D3) / 4);
  localparam logic [CNT_W-1:0] DT4 = CNT_W'((5 * D4) / 4);

  // Dotted when the length reaches 1.25x the chosen (non-whole) duration.
  always_comb begin
    dotted_o = 1'b0;
    case (dur_o)
      DUR_16TH:    dotted_o = (len_i >= DT1);
      DUR_8TH:     dotted_o = (len_i >= DT2);
      DUR_QUARTER: dotted_o = (len_i >= DT3);
      DUR_HALF:    dotted_o = (len_i >= DT4);
      default:     dotted_o = 1'b0;
    endcase
  end
`else
  assign dotted_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/note_duration_quantizer.sv
// ============================================================================
// Module   : note_duration_quantizer
// Brief    : Debounces a stream of tone indices into note segments and emits
//            one quantized duration event per finished segment (valid/ready
//            output with sticky overflow). Optional macro
//            NOTE_DURATION_DOTTED_EN enables the dotted-note flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module note_duration_quantizer
  import music_pkg::*;
#(
  parameter int SAMPLE_RATE = 17000,
  parameter int BPM         = 60,
  parameter int TONE_W      = TONE_W_DEFAULT,
  parameter int MIN_SAMPLES = 4
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [TONE_W-1:0] note_index,
  input  logic              note_index_ready,
  output logic              ev_valid,
  input  logic              ev_ready,
  output logic [TONE_W-1:0] ev_tone,
  output logic [2:0]        ev_dur,
  output logic              ev_rest,
  output logic              ev_dotted,
  output logic              ev_tie,
  output logic              overflow
);

  localparam int unsigned D5     = dur_samples(SAMPLE_RATE, BPM, 5);
  localparam int          CNT_W  = $clog2(D5 + 1);
  localparam int          PEND_W = (MIN_SAMPLES < 2) ? 1 : $clog2(MIN_SAMPLES + 1);

  localparam logic [CNT_W-1:0]  D5_C    = CNT_W'(D5);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;
  localparam logic [CNT_W-1:0]  MIN_C   = CNT_W'(MIN_SAMPLES);
  localparam logic [CNT_W-1:0]  LEN_OFF = CNT_W'(MIN_SAMPLES - 1);
  localparam logic [PEND_W-1:0] MIN_P   = PEND_W'(MIN_SAMPLES);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_PEND  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [TONE_W-1:0]   tone_q, tone_d;
  logic [TONE_W-1:0]   cand_q, cand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [PEND_W-1:0]   pend_q, pend_d;

  logic                emit;
  logic                emit_tie;
  logic [2:0]          emit_dur;
  logic                emit_dotted;

  logic [CNT_W-1:0]    cnt_inc;
  logic [CNT_W-1:0]    seg_len;
  logic [2:0]          cls_dur;
  logic                cls_dotted;

  logic                ev_valid_q, ev_rest_q, ev_dotted_q, ev_tie_q, ovf_q;
  logic [TONE_W-1:0]   ev_tone_q;
  logic [2:0]          ev_dur_q;

  // Saturate so a never-ending debounce cannot wrap the counter.
  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

  // The candidate's own samples are already counted in cnt_q; remove them.
  assign seg_len = (cnt_q >= LEN_OFF) ? cnt_q - LEN_OFF : '0;

  dur_classify #(
    .SAMPLE_RATE (SAMPLE_RATE),
    .BPM         (BPM),
    .CNT_W       (CNT_W)
  ) u_classify (
    .len_i    (seg_len),
    .dur_o    (cls_dur),
    .dotted_o (cls_dotted)
  );

  // Segment tracking and debounce; decides when an event is produced.
  always_comb begin
    state_d     = state_q;
    tone_d      = tone_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    emit        = 1'b0;
    emit_tie    = 1'b0;
    emit_dur    = DUR_NONE;
    emit_dotted = 1'b0;
    if (note_index_ready) begin
      case (state_q)
        ST_IDLE: begin
          tone_d  = note_index;
          cnt_d   = CNT_W'(1);
          pend_d  = '0;
          state_d = ST_TRACK;
        end
        ST_TRACK: begin
          if (note_index == tone_q) begin
            if (cnt_inc >= D5_C) begin
              emit     = 1'b1;
              emit_tie = 1'b1;
              emit_dur = DUR_WHOLE;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else if (MIN_SAMPLES <= 1) begin
            emit        = (cls_dur != DUR_NONE);
            emit_dur    = cls_dur;
            emit_dotted = cls_dotted;
            tone_d      = note_index;
            cnt_d       = MIN_C;
            pend_d      = '0;
          end else begin
            cand_d  = note_index;
            pend_d  = PEND_W'(1);
            cnt_d   = cnt_inc;
            state_d = ST_PEND;
          end
        end
        ST_PEND: begin
          cnt_d = cnt_inc;
          if (note_index == tone_q) begin
            pend_d  = '0;
            state_d = ST_TRACK;
          end else if (note_index == cand_q) begin
            if (pend_q + PEND_W'(1) >= MIN_P) begin
              emit        = (cls_dur != DUR_NONE);
              emit_dur    = cls_dur;
              emit_dotted = cls_dotted;
              tone_d      = cand_q;
              cnt_d       = MIN_C;
              pend_d      = '0;
              state_d     = ST_TRACK;
            end else begin
              pend_d = pend_q + PEND_W'(1);
            end
          end else begin
            cand_d = note_index;
            pend_d = PEND_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Tracking state register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      tone_q  <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      tone_q  <= tone_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Output holding register: keeps a pending event, drops new ones on stall.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      ev_valid_q  <= 1'b0;
      ev_tone_q   <= '0;
      ev_dur_q    <= '0;
      ev_rest_q   <= 1'b0;
      ev_dotted_q <= 1'b0;
      ev_tie_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (emit) begin
      if (ev_valid_q && !ev_ready) begin
        ovf_q <= 1'b1;
      end else begin
        ev_valid_q  <= 1'b1;
        ev_tone_q   <= tone_q;
        ev_dur_q    <= emit_dur;
        ev_rest_q   <= (tone_q == '0);
        ev_dotted_q <= emit_dotted;
        ev_tie_q    <= emit_tie;
      end
    end else if (ev_valid_q && ev_ready) begin
      ev_valid_q <= 1'b0;
    end
  end

  assign ev_valid  = ev_valid_q;
  assign ev_tone   = ev_tone_q;
  assign ev_dur    = ev_dur_q;
  assign ev_rest   = ev_rest_q;
  assign ev_dotted = ev_dotted_q;
  assign ev_tie    = ev_tie_q;
  assign overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_note_duration_quantizer.sv
// ============================================================================
// Module   : tb_note_duration_quantizer
// Brief    : Scoreboard bench for note_duration_quantizer (SAMPLE_RATE=64,
//            BPM=60, MIN_SAMPLES=2). Honours NOTE_DURATION_DOTTED_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_note_duration_quantizer;

  localparam int SR     = 64;
  localparam int BPM    = 60;
  localparam int TONE_W = 6;
  localparam int MINS   = 2;

  logic              clk_in;
  logic              rst_in;
  logic [TONE_W-1:0] note_index;
  logic              note_index_ready;
  logic              ev_valid;
  logic              ev_ready;
  logic [TONE_W-1:0] ev_tone;
  logic [2:0]        ev_dur;
  logic              ev_rest;
  logic              ev_dotted;
  logic              ev_tie;
  logic              overflow;

  typedef struct {
    int tone;
    int dur;
    int dot;
    int tie;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  note_duration_quantizer #(
    .SAMPLE_RATE (SR),
    .BPM         (BPM),
    .TONE_W      (TONE_W),
    .MIN_SAMPLES (MINS)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .note_index       (note_index),
    .note_index_ready (note_index_ready),
    .ev_valid         (ev_valid),
    .ev_ready         (ev_ready),
    .ev_tone          (ev_tone),
    .ev_dur           (ev_dur),
    .ev_rest          (ev_rest),
    .ev_dotted        (ev_dotted),
    .ev_tie           (ev_tie),
    .overflow         (overflow)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Expected duration code and dotted flag of a segment of len samples.
  function automatic void classify(input int len, output int dur, output int dot);
    int d[6];
    int q;
    q    = SR * 60 / BPM;
    d[1] = q / 4;
    d[2] = q / 2;
    d[3] = q;
    d[4] = 2 * q;
    d[5] = 4 * q;
    dur  = 0;
    for (int k = 1; k <= 5; k++)
      if (len >= 3 * d[k] / 4) dur = k;
    dot = 0;
`ifdef NOTE_DURATION_DOTTED_EN
    if (dur > 0 && dur < 5 && len >= 5 * d[dur] / 4) dot = 1;
`endif
  endfunction

  task automatic expect_seg(input int tone, input int len);
    ev_t e;
    int  dur, dot;
    classify(len, dur, dot);
    if (dur > 0) begin
      e.tone = tone; e.dur = dur; e.dot = dot; e.tie = 0;
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_tie(input int tone);
    ev_t e;
    e.tone = tone; e.dur = 5; e.dot = 0; e.tie = 1;
    exp_q.push_back(e);
  endtask

  // One strobed sample followed by an idle cycle carrying junk on note_index.
  task automatic send(input int tone, input int n);
    for (int i = 0; i < n; i++) begin
      note_index       = TONE_W'(tone);
      note_index_ready = 1'b1;
      @(posedge clk_in); #1;
      note_index_ready = 1'b0;
      note_index       = TONE_W'($urandom);
      @(posedge clk_in); #1;
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    repeat (4) @(posedge clk_in);
    #1;
    check_eq(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Scoreboard side: every accepted event is compared with the queue head.
  always @(negedge clk_in) begin
    if (!rst_in && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_event", 1, 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check_eq("ev_tone", ev_tone, e.tone);
        check_eq("ev_dur", ev_dur, e.dur);
        check_eq("ev_dotted", ev_dotted, e.dot);
        check_eq("ev_tie", ev_tie, e.tie);
        check_eq("ev_rest", ev_rest, (e.tone == 0));
      end
    end
  end

  initial begin
    rst_in           = 1'b1;
    note_index       = '0;
    note_index_ready = 1'b0;
    ev_ready         = 1'b1;
    @(posedge clk_in); #1;
    check_eq("rst_valid", ev_valid, 0);
    check_eq("rst_tone", ev_tone, 0);
    check_eq("rst_dur", ev_dur, 0);
    check_eq("rst_ovf", overflow, 0);
    rst_in = 1'b0;

    // Reset in the middle of a debounce discards the interrupted segment.
    send(4, 30); send(8, 1);
    do_reset();
    expect_seg(1, 20);
    send(1, 20); send(2, 2);
    drain("mid_reset_seg");

    // Quarter note, with latency check on the accepting sample.
    do_reset();
    expect_seg(5, 64);
    send(5, 64); send(7, 1);
    note_index = 7; note_index_ready = 1'b1;
    @(posedge clk_in); #1;
    check_eq("latency", ev_valid, 1);
    note_index_ready = 1'b0;
    drain("sc_quarter");

    // Single-sample glitch is absorbed into the running segment.
    do_reset();
    expect_seg(5, 71);
    send(5, 40); send(9, 1); send(5, 30); send(0, 2);
    drain("sc_glitch");

    // Tie at a whole note, then the remainder.
    do_reset();
    expect_tie(3);
    expect_seg(3, 44);
    send(3, 300); send(0, 2);
    drain("sc_tie");

    // Exact quarter threshold.
    do_reset();
    expect_seg(2, 48);
    send(2, 48); send(4, 2);
    drain("sc_48");

    // Rest segment.
    do_reset();
    expect_seg(0, 20);
    send(0, 20); send(1, 2);
    drain("sc_rest");

    // 11 samples is below the shortest threshold; 12 reaches it.
    do_reset();
    expect_seg(7, 12);
    send(6, 11); send(7, 12); send(8, 2);
    drain("sc_short");

    // Stall: second event dropped, first held, overflow sticky.
    do_reset();
    ev_ready = 1'b0;
    expect_seg(5, 20);
    send(5, 20); send(6, 20); send(7, 2);
    check_eq("hold_valid", ev_valid, 1);
    check_eq("hold_tone", ev_tone, 5);
    check_eq("hold_dur", ev_dur, 1);
    check_eq("ovf_set", overflow, 1);
    ev_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    #1;
    check_eq("valid_drop", ev_valid, 0);
    check_eq("ovf_sticky", overflow, 1);
    check_eq("stall_queue", exp_q.size(), 0);

    // Asynchronous reset between clock edges.
    send(2, 5);
    #3;
    rst_in = 1'b1;
    #1;
    check_eq("arst_valid", ev_valid, 0);
    check_eq("arst_tone", ev_tone, 0);
    check_eq("arst_dur", ev_dur, 0);
    check_eq("arst_ovf", overflow, 0);
    check_eq("arst_tie", ev_tie, 0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
